// File: rtl/dff_share_arb_if.sv
// Requester-side bundle for dff_share_arb: request/data in, grant/done/shared value out.
// DFF_ARB_PARITY_EN adds out_par alongside out.
interface dff_share_arb_if #(
    parameter int SIZE = 5,
    parameter int NREQ = 4
);
    logic [NREQ-1:0]      req;
    logic [NREQ*SIZE-1:0] din;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      done;
    logic [SIZE-1:0]      out;
    logic                 busy;
`ifdef DFF_ARB_PARITY_EN
    logic                 out_par;

    modport master (output req, din, input gnt, done, out, busy, out_par);
    modport slave  (input req, din, output gnt, done, out, busy, out_par);
`else
    modport master (output req, din, input gnt, done, out, busy);
    modport slave  (input req, din, output gnt, done, out, busy);
`endif
endinterface

// File: rtl/dff_share_arb.sv
// Round-robin arbiter feeding one shared delayed-write register; commit DELAY cycles after grant,
// requesters hold req until their done pulse. DFF_ARB_PARITY_EN adds registered even parity of out.
module dff_share_arb #(
    parameter int SIZE  = 5,
    parameter int NREQ  = 4,
    parameter int DELAY = 1
) (
    input  logic            clk,
    input  logic            rst,
    dff_share_arb_if.slave  bus
);
    localparam int LW = $clog2(NREQ);
    localparam int CW = $clog2(DELAY) + 1;

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t            r_state;
    logic [NREQ-1:0]   r_gnt;
    logic [NREQ-1:0]   r_done;
    logic [SIZE-1:0]   r_out;
    logic [SIZE-1:0]   r_data;
    logic              r_busy;
    logic [CW-1:0]     r_count;
    logic [LW-1:0]     r_last;
`ifdef DFF_ARB_PARITY_EN
    logic              r_out_par;
`endif

    logic [NREQ-1:0]   w_eff;
    logic [2*NREQ-1:0] w_dbl;
    logic [NREQ-1:0]   w_rot;
    logic [LW:0]       w_sh;
    logic [LW:0]       w_sum;
    logic [LW-1:0]     w_off;
    logic [LW-1:0]     w_sel;
    logic              w_found;
    logic [NREQ-1:0]   w_oh;
    logic [SIZE-1:0]   w_din_sel;

    // Masking with the registered done stops a requester being re-granted while it drops req.
    assign w_eff   = bus.req & ~r_done;
    assign w_dbl   = {w_eff, w_eff};
    assign w_sh    = {1'b0, r_last} + (LW+1)'(1);
    assign w_rot   = NREQ'(w_dbl >> w_sh);
    assign w_found = |w_rot;

    always_comb begin
        w_off = '0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_off = LW'(j);
            end
        end
    end

    // Rotated offset back to an absolute requester index, modulo NREQ.
    assign w_sum = w_sh + {1'b0, w_off};
    assign w_sel = (w_sum >= (LW+1)'(NREQ)) ? LW'(w_sum - (LW+1)'(NREQ)) : LW'(w_sum);
    assign w_oh  = {{(NREQ-1){1'b0}}, 1'b1} << w_sel;

    always_comb begin
        w_din_sel = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_sel == LW'(k)) begin
                w_din_sel = bus.din[k*SIZE +: SIZE];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_gnt     <= '0;
            r_done    <= '0;
            r_out     <= '0;
            r_data    <= '0;
            r_busy    <= 1'b0;
            r_count   <= '0;
            r_last    <= LW'(NREQ - 1);
`ifdef DFF_ARB_PARITY_EN
            r_out_par <= 1'b0;
`endif
        end else begin
            r_done <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_gnt   <= w_oh;
                        r_data  <= w_din_sel;
                        r_count <= CW'(DELAY - 1);
                        r_last  <= w_sel;
                        r_busy  <= 1'b1;
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_count != '0) begin
                        r_count <= r_count - CW'(1);
                    end else begin
                        r_out     <= r_data;
`ifdef DFF_ARB_PARITY_EN
                        r_out_par <= ^r_data;
`endif
                        r_done    <= r_gnt;
                        r_gnt     <= '0;
                        r_busy    <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.gnt  = r_gnt;
    assign bus.done = r_done;
    assign bus.out  = r_out;
    assign bus.busy = r_busy;
`ifdef DFF_ARB_PARITY_EN
    assign bus.out_par = r_out_par;
`endif
endmodule

// File: tb/tb_dff_share_arb.sv
// Directed bench: three arbiters (DELAY 1, 3, 5) exercised in turn with hand-computed expectations.
module tb_dff_share_arb;
    logic clk;
    logic rst_a, rst_b, rst_c;
    int   checks;
    int   failures;

    dff_share_arb_if #(.SIZE(5), .NREQ(4)) if_a ();
    dff_share_arb_if #(.SIZE(5), .NREQ(4)) if_b ();
    dff_share_arb_if #(.SIZE(5), .NREQ(4)) if_c ();

    dff_share_arb #(.SIZE(5), .NREQ(4), .DELAY(1)) u_a (.clk(clk), .rst(rst_a), .bus(if_a.slave));
    dff_share_arb #(.SIZE(5), .NREQ(4), .DELAY(3)) u_b (.clk(clk), .rst(rst_b), .bus(if_b.slave));
    dff_share_arb #(.SIZE(5), .NREQ(4), .DELAY(5)) u_c (.clk(clk), .rst(rst_c), .bus(if_c.slave));

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk5(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] oh;
        logic [4:0] pv [3];
        logic       pp [3];

        checks   = 0;
        failures = 0;
        clk      = 1'b0;
        rst_a    = 1'b1;
        rst_b    = 1'b1;
        rst_c    = 1'b1;
        if_a.req = '0; if_a.din = '0;
        if_b.req = '0; if_b.din = '0;
        if_c.req = '0; if_c.din = '0;

        // ---- Instance A (DELAY=1): reset with all requests high ----
        if_a.req = 4'b1111;
        if_a.din[0*5 +: 5] = 5'h01;
        for (int r = 0; r < 2; r++) begin
            tick();
            chk4("rst_gnt", if_a.gnt, 4'b0000);
            chk4("rst_done", if_a.done, 4'b0000);
            chk5("rst_out", if_a.out, 5'h00);
            chk1("rst_busy", if_a.busy, 1'b0);
`ifdef DFF_ARB_PARITY_EN
            chk1("rst_par", if_a.out_par, 1'b0);
`endif
        end
        rst_a = 1'b0;
        tick();
        chk4("first_gnt_req0", if_a.gnt, 4'b0001);
        chk1("first_busy", if_a.busy, 1'b1);
        if_a.req = 4'b0000;
        tick();
        chk4("first_done", if_a.done, 4'b0001);
        chk5("first_out", if_a.out, 5'h01);
        chk1("first_busy_low", if_a.busy, 1'b0);

        // ---- Single write from requester 2 ----
        if_a.req = 4'b0100;
        if_a.din[2*5 +: 5] = 5'h15;
        tick();
        chk4("single_gnt", if_a.gnt, 4'b0100);
        chk1("single_busy", if_a.busy, 1'b1);
        chk5("single_out_hold", if_a.out, 5'h01);
        chk4("single_done_low", if_a.done, 4'b0000);
        if_a.req = 4'b0000;
        tick();
        chk5("single_out", if_a.out, 5'h15);
        chk4("single_done", if_a.done, 4'b0100);
        chk4("single_gnt_low", if_a.gnt, 4'b0000);
        chk1("single_busy_low", if_a.busy, 1'b0);
        tick();
        chk4("single_done_once", if_a.done, 4'b0000);

        // ---- Masking: requester 0 keeps req high through its done cycle ----
        if_a.req = 4'b0001;
        if_a.din[0*5 +: 5] = 5'h0C;
        tick();
        chk4("mask_gnt", if_a.gnt, 4'b0001);
        tick();
        chk4("mask_done", if_a.done, 4'b0001);
        chk5("mask_out", if_a.out, 5'h0C);
        tick();
        chk4("mask_no_regrant", if_a.gnt, 4'b0000);
        chk1("mask_busy", if_a.busy, 1'b0);
        if_a.req = 4'b0000;
        tick();

`ifdef DFF_ARB_PARITY_EN
        pv[0] = 5'b10110; pp[0] = 1'b1;
        pv[1] = 5'b00111; pp[1] = 1'b1;
        pv[2] = 5'b00011; pp[2] = 1'b0;
        for (int p = 0; p < 3; p++) begin
            if_a.req = 4'b0010;
            if_a.din[1*5 +: 5] = pv[p];
            tick();
            if_a.req = 4'b0000;
            tick();
            chk5("par_out", if_a.out, pv[p]);
            chk1("par_bit", if_a.out_par, pp[p]);
            tick();
        end
`else
        pv[0] = '0; pp[0] = 1'b0;
`endif

        // ---- Instance B (DELAY=3): round robin with all requests held ----
        rst_b = 1'b0;
        for (int i = 0; i < 4; i++) if_b.din[i*5 +: 5] = 5'(i + 1);
        if_b.req = 4'b1111;
        for (int g = 0; g < 4; g++) begin
            oh = 4'b0001 << g;
            tick();
            chk4("rr_gnt", if_b.gnt, oh);
            chk1("rr_busy", if_b.busy, 1'b1);
            tick();
            tick();
            chk4("rr_gnt_held", if_b.gnt, oh);
            chk4("rr_done_low", if_b.done, 4'b0000);
            tick();
            chk5("rr_out", if_b.out, 5'(g + 1));
            chk4("rr_done", if_b.done, oh);
            chk4("rr_gnt_drop", if_b.gnt, 4'b0000);
        end

        // ---- Wrap from last=3 with req=1001, requester 0 held through done ----
        if_b.req = 4'b1001;
        tick();
        chk4("wrap_gnt0", if_b.gnt, 4'b0001);
        tick(); tick(); tick();
        chk4("wrap_done0", if_b.done, 4'b0001);
        chk5("wrap_out0", if_b.out, 5'h01);
        tick();
        chk4("wrap_gnt3", if_b.gnt, 4'b1000);
        // req dropped and din changed mid-WAIT: commit still uses captured data
        if_b.req = 4'b0000;
        if_b.din[3*5 +: 5] = 5'h1F;
        tick(); tick(); tick();
        chk5("wrap_out3", if_b.out, 5'h04);
        chk4("wrap_done3", if_b.done, 4'b1000);

        // ---- Instance C (DELAY=5): full commit, then aborted transaction ----
        rst_c = 1'b0;
        if_c.req = 4'b0100;
        if_c.din[2*5 +: 5] = 5'h1B;
        tick();
        chk4("c_gnt2", if_c.gnt, 4'b0100);
        if_c.req = 4'b0000;
        for (int w = 0; w < 5; w++) tick();
        chk5("c_out", if_c.out, 5'h1B);
        chk4("c_done", if_c.done, 4'b0100);
        tick();
        if_c.req = 4'b0010;
        if_c.din[1*5 +: 5] = 5'h0A;
        tick();
        chk4("abort_gnt1", if_c.gnt, 4'b0010);
        if_c.req = 4'b0000;
        tick();
        tick();
        chk4("abort_gnt_held", if_c.gnt, 4'b0010);
        chk5("abort_out_hold", if_c.out, 5'h1B);
        rst_c = 1'b1;
        tick();
        chk5("abort_out", if_c.out, 5'h00);
        chk4("abort_done", if_c.done, 4'b0000);
        chk4("abort_gnt", if_c.gnt, 4'b0000);
        chk1("abort_busy", if_c.busy, 1'b0);
        rst_c = 1'b0;
        tick();
        chk4("abort_no_done", if_c.done, 4'b0000);
        chk1("abort_idle", if_c.busy, 1'b0);
        if_c.req = 4'b1111;
        if_c.din[0*5 +: 5] = 5'h11;
        tick();
        chk4("abort_next_gnt0", if_c.gnt, 4'b0001);
        if_c.req = 4'b0000;
        for (int w = 0; w < 5; w++) tick();
        chk5("abort_next_out", if_c.out, 5'h11);
        chk4("abort_next_done", if_c.done, 4'b0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
